// File: rtl/uart_rx.sv
// UART receiver for a 16x oversampling clock: synchronizes rx, finds and validates
// the start bit, samples each bit at mid-bit, checks optional parity and the stop bit.
module uart_rx #(
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0,
    parameter int unsigned SYNC_STAGES = 2      // minimum 2
) (
    input  logic       mclkx16,
    input  logic       reset,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] data,
    output logic       rxrdy,
    output logic       framing_error,
    output logic       parity_error,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic [7:0]             data_q, data_d;
    logic                   rxrdy_q, rxrdy_d;
    logic                   fe_q, fe_d;
    logic                   pe_q, pe_d;
    logic                   ov_q, ov_d;
    logic                   rx_s;
    logic                   frame_done;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        cnt_d      = cnt_q + 4'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (cnt_q == 4'd7) begin
                    cnt_d     = 4'd0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == 4'd15) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == 4'd15) begin
                    par_err_d = rx_s ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Released at mid-stop so a following start bit is not missed.
                if (cnt_q == 4'd15) begin
                    frame_done = 1'b1;
                    state_d    = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_d = 4'd0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        rxrdy_d = rxrdy_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ov_d    = ov_q;
        // A completion takes priority over a simultaneous read acknowledge.
        if (frame_done) begin
            data_d  = shift_q;
            fe_d    = ~rx_s;
            pe_d    = PARITY_EN ? par_err_q : 1'b0;
            rxrdy_d = 1'b1;
            if (rxrdy_q && !read) begin
                ov_d = 1'b1;
            end
        end else if (read && rxrdy_q) begin
            rxrdy_d = 1'b0;
            ov_d    = 1'b0;
        end
    end

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sync_q    <= '1;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_err_q <= 1'b0;
            data_q    <= 8'h00;
            rxrdy_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            rxrdy_q   <= rxrdy_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ov_q      <= ov_d;
        end
    end

    assign data          = data_q;
    assign rxrdy         = rxrdy_q;
    assign framing_error = fe_q;
    assign parity_error  = pe_q;
    assign overrun       = ov_q;

endmodule
